regfile_write_arbiter: RTL and testbench
========================================

REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

Interface
- REQ-001 The block SHALL use one clock and one reset: a single clock `clock`, and an asynchronous, active-high reset `reset`.
- REQ-002 `clock`  in  1  rising-edge clock for all state.
- REQ-003 `reset`  in  1  asynchronous, active-high; clears all state.
- REQ-004 `alu_valid`  in  1  ALU writeback request present.
- REQ-005 `alu_addr`  in  3  ALU destination register.
- REQ-006 `alu_data`  in  8  ALU result.
- REQ-007 `alu_ready`  out  1  ALU request accepted this cycle (combinational).
- REQ-008 `mem_valid`  in  1  load writeback request present.
- REQ-009 `mem_addr`  in  3  load destination register.
- REQ-010 `mem_data`  in  8  load data.
- REQ-011 `mem_ready`  out  1  load request accepted this cycle (combinational).
- REQ-012 `RegWrite`  out  1  write strobe to the register bank (registered).
- REQ-013 `EscReg`  out  3  write address to the register bank (registered).
- REQ-014 `WriteData`  out  8  write data to the register bank (registered).
- REQ-015 `last_grant`  out  1  requester most recently granted (0 = ALU, 1 = mem).
- REQ-016 `drop_count`  out  8  saturating count of discarded writes to r0.

Function
- REQ-017 Handshake: a request transfers on a rising edge where `valid` && `ready` for that requester; a requester SHALL hold `addr`/`data` stable while `valid` && !`ready`.
- REQ-018 Arbitration is combinational from `alu_valid`, `mem_valid` and `last_grant`; at most one `ready` SHALL be high per cycle.
- REQ-019 If only one requester is valid, it SHALL be granted (`ready` = 1) the same cycle.
- REQ-020 If both are valid, the requester not equal to `last_grant` SHALL be granted (round robin).
- REQ-021 If neither is valid, both `ready` SHALL be 0 and `last_grant` SHALL hold.
- REQ-022 On each transfer, `last_grant` SHALL update to the granted requester at that edge.
- REQ-023 Latency: a transfer with addr != 0 at edge N SHALL drive `RegWrite` = 1, `EscReg` = addr, `WriteData` = data for exactly the cycle following edge N.
- REQ-024 With no transfer at an edge, `RegWrite` SHALL be 0 in the following cycle.
- REQ-025 `EscReg`/`WriteData` SHALL hold their last values when `RegWrite` = 0.
- REQ-026 r0 rule: a transfer with addr = 0 SHALL be accepted normally and update `last_grant`, but SHALL produce `RegWrite` = 0.
- REQ-027 An r0 transfer SHALL increment `drop_count` by 1, saturating at 255 (no wrap).
- REQ-028 Same-address collision: when both requesters are valid with equal addr, the loser is written one or more cycles later, so the loser's data is the final register value. No merging or suppression SHALL occur.
- REQ-029 Throughput: one write per cycle sustained, with no idle cycle between back-to-back transfers.
- REQ-030 No state machine beyond the `last_grant` flop and the output register; no buffering of requests inside the block.

Reset
- REQ-031 While `reset` = 1: `RegWrite` = 0, `EscReg` = 0, `WriteData` = 0, `last_grant` = 1 (so the ALU wins the first tie), `drop_count` = 0.
- REQ-032 `ready` outputs SHALL be 0 while `reset` = 1.
- REQ-033 An assertion of `reset` mid-operation SHALL discard any write due in the next cycle, so no `RegWrite` pulse follows a reset edge.
- REQ-034 After `reset` deasserts, arbitration SHALL resume on the first rising edge.

Verification
- REQ-035 Single ALU request (addr 3, data 0x5A): `alu_ready` = 1 at once; the next cycle has `RegWrite` = 1, `EscReg` = 3, `WriteData` = 0x5A, `mem_ready` = 0.
- REQ-036 Both valid for 4 cycles after reset (ALU r1/0x11, mem r2/0x22, held): grants go ALU, mem, ALU, mem; `RegWrite` is continuous from the second cycle.
- REQ-037 Collision: both valid with addr 5 (ALU 0xAA, mem 0xBB) right after reset: ALU is written first, mem second; the final strobe carries 0xBB.
- REQ-038 r0 discard: 300 ALU transfers to addr 0: `RegWrite` stays 0 throughout, `drop_count` = 255, and `last_grant` = 0.
- REQ-039 Reset mid-transfer: `reset` asserts asynchronously in the cycle after an accepted mem write: `RegWrite` drops to 0 immediately, and no pulse occurs after reset release.
- REQ-040 Idle gaps: alternating valid/invalid cycles on mem only: every transfer produces exactly one `RegWrite` pulse, and `RegWrite` = 0 in each cycle following an idle edge.

Source files
------------

// File: rtl/regfile_write_arbiter.sv
// Register-bank write arbiter for two writeback sources (ALU and load unit).
// Round-robin between the two requesters, one write per cycle, registered
// write port toward the register bank. Writes to r0 are accepted but dropped,
// and a saturating counter records how many were dropped.
module regfile_write_arbiter (
  input  logic       clock,
  input  logic       reset,

  input  logic       alu_valid,
  input  logic [2:0] alu_addr,
  input  logic [7:0] alu_data,
  output logic       alu_ready,

  input  logic       mem_valid,
  input  logic [2:0] mem_addr,
  input  logic [7:0] mem_data,
  output logic       mem_ready,

  output logic       RegWrite,
  output logic [2:0] EscReg,
  output logic [7:0] WriteData,

  output logic       last_grant,
  output logic [7:0] drop_count
);

  // Requester encoding used by last_grant.
  localparam logic GRANT_ALU = 1'b0;
  localparam logic GRANT_MEM = 1'b1;

  // Saturation ceiling of the r0 drop counter.
  localparam logic [7:0] DROP_MAX = 8'hFF;

  // Round-robin history: which requester won the most recent transfer.
  logic       last_grant_q;
  logic       last_grant_d;

  // Registered write port toward the register bank.
  logic       reg_write_q;
  logic       reg_write_d;
  logic [2:0] esc_reg_q;
  logic [2:0] esc_reg_d;
  logic [7:0] write_data_q;
  logic [7:0] write_data_d;

  // Saturating count of transfers that targeted r0.
  logic [7:0] drop_count_q;
  logic [7:0] drop_count_d;

  // Arbitration results for the current cycle.
  logic       grant_alu;
  logic       grant_mem;
  logic       xfer;
  logic [2:0] sel_addr;
  logic [7:0] sel_data;
  logic       sel_is_r0;

  // Combinational arbitration: a lone requester wins outright; on a tie the
  // requester that did not win last time goes first. Nothing is granted
  // while reset is held so no transfer can be claimed during reset.
  always_comb begin
    grant_alu = 1'b0;
    grant_mem = 1'b0;
    if (!reset) begin
      if (alu_valid && mem_valid) begin
        grant_alu = (last_grant_q == GRANT_MEM);
        grant_mem = (last_grant_q == GRANT_ALU);
      end else begin
        grant_alu = alu_valid;
        grant_mem = mem_valid;
      end
    end
  end

  // Steer the winning requester's address and data onto the write path.
  always_comb begin
    sel_addr = 3'd0;
    sel_data = 8'd0;
    if (grant_mem) begin
      sel_addr = mem_addr;
      sel_data = mem_data;
    end else if (grant_alu) begin
      sel_addr = alu_addr;
      sel_data = alu_data;
    end
    xfer      = grant_alu || grant_mem;
    sel_is_r0 = (sel_addr == 3'd0);
  end

  // Next-state for the grant history, write port and drop counter. Address
  // and data hold whenever no write is issued so the bank sees stable values.
  always_comb begin
    last_grant_d = last_grant_q;
    reg_write_d  = 1'b0;
    esc_reg_d    = esc_reg_q;
    write_data_d = write_data_q;
    drop_count_d = drop_count_q;

    if (xfer) begin
      last_grant_d = grant_mem ? GRANT_MEM : GRANT_ALU;
      if (sel_is_r0) begin
        if (drop_count_q != DROP_MAX) begin
          drop_count_d = drop_count_q + 8'd1;
        end
      end else begin
        reg_write_d  = 1'b1;
        esc_reg_d    = sel_addr;
        write_data_d = sel_data;
      end
    end
  end

  // State registers; reset is asynchronous so a pending write strobe is
  // killed the moment reset rises. last_grant resets to mem so the ALU wins
  // the first tie.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      last_grant_q <= GRANT_MEM;
      reg_write_q  <= 1'b0;
      esc_reg_q    <= 3'd0;
      write_data_q <= 8'd0;
      drop_count_q <= 8'd0;
    end else begin
      last_grant_q <= last_grant_d;
      reg_write_q  <= reg_write_d;
      esc_reg_q    <= esc_reg_d;
      write_data_q <= write_data_d;
      drop_count_q <= drop_count_d;
    end
  end

  // Drive the ports.
  assign alu_ready  = grant_alu;
  assign mem_ready  = grant_mem;
  assign RegWrite   = reg_write_q;
  assign EscReg     = esc_reg_q;
  assign WriteData  = write_data_q;
  assign last_grant = last_grant_q;
  assign drop_count = drop_count_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter: single request, round robin,
// same-address collision, r0 discard with saturation, asynchronous reset
// mid-transfer, and idle gaps on one requester.
module tb_regfile_write_arbiter;

  logic       clock;
  logic       reset;
  logic       alu_valid;
  logic [2:0] alu_addr;
  logic [7:0] alu_data;
  logic       alu_ready;
  logic       mem_valid;
  logic [2:0] mem_addr;
  logic [7:0] mem_data;
  logic       mem_ready;
  logic       RegWrite;
  logic [2:0] EscReg;
  logic [7:0] WriteData;
  logic       last_grant;
  logic [7:0] drop_count;

  int checksTotal;
  int checksPassed;
  int writePulses;

  regfile_write_arbiter dut (
    .clock      (clock),
    .reset      (reset),
    .alu_valid  (alu_valid),
    .alu_addr   (alu_addr),
    .alu_data   (alu_data),
    .alu_ready  (alu_ready),
    .mem_valid  (mem_valid),
    .mem_addr   (mem_addr),
    .mem_data   (mem_data),
    .mem_ready  (mem_ready),
    .RegWrite   (RegWrite),
    .EscReg     (EscReg),
    .WriteData  (WriteData),
    .last_grant (last_grant),
    .drop_count (drop_count)
  );

  // Free-running 10 ns clock.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Drive both requester interfaces at once.
  task automatic applyStimulus(input logic av, input logic [2:0] aa, input logic [7:0] ad,
                               input logic mv, input logic [2:0] ma, input logic [7:0] md);
    alu_valid = av;
    alu_addr  = aa;
    alu_data  = ad;
    mem_valid = mv;
    mem_addr  = ma;
    mem_data  = md;
  endtask

  // Compare one observed value against its expected value.
  task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    checksTotal++;
    assert (observed === expected) begin
      checksPassed++;
    end else begin
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic stepClock;
    @(posedge clock);
    #2;
  endtask

  // Pulse reset for one edge with both requesters idle.
  task automatic pulseReset;
    applyStimulus(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00);
    reset = 1'b1;
    stepClock();
    reset = 1'b0;
  endtask

  initial begin
    checksTotal  = 0;
    checksPassed = 0;
    writePulses  = 0;

    // Reset state, with both requesters asserting valid to prove ready is gated.
    reset = 1'b1;
    applyStimulus(1'b1, 3'd3, 8'h5A, 1'b1, 3'd4, 8'h66);
    #3;
    checkOutput("rst_alu_ready", alu_ready, 0);
    checkOutput("rst_mem_ready", mem_ready, 0);
    checkOutput("rst_regwrite", RegWrite, 0);
    checkOutput("rst_escreg", EscReg, 0);
    checkOutput("rst_writedata", WriteData, 0);
    checkOutput("rst_last_grant", last_grant, 1);
    checkOutput("rst_drop_count", drop_count, 0);
    stepClock();
    stepClock();
    checkOutput("rst_hold_regwrite", RegWrite, 0);

    // Single ALU request: granted at once, written the next cycle.
    reset = 1'b0;
    applyStimulus(1'b1, 3'd3, 8'h5A, 1'b0, 3'd0, 8'h00);
    #1;
    checkOutput("single_alu_ready", alu_ready, 1);
    checkOutput("single_mem_ready", mem_ready, 0);
    stepClock();
    applyStimulus(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00);
    #1;
    checkOutput("single_regwrite", RegWrite, 1);
    checkOutput("single_escreg", EscReg, 3);
    checkOutput("single_writedata", WriteData, 8'h5A);
    checkOutput("single_last_grant", last_grant, 0);
    checkOutput("single_next_mem_ready", mem_ready, 0);
    stepClock();
    checkOutput("idle_regwrite", RegWrite, 0);
    checkOutput("idle_escreg_hold", EscReg, 3);
    checkOutput("idle_writedata_hold", WriteData, 8'h5A);
    checkOutput("idle_last_grant_hold", last_grant, 0);

    // Round robin: both valid and held for four cycles after reset.
    pulseReset();
    applyStimulus(1'b1, 3'd1, 8'h11, 1'b1, 3'd2, 8'h22);
    for (int i = 0; i < 4; i++) begin
      #1;
      checkOutput($sformatf("rr%0d_alu_ready", i), alu_ready, (i % 2 == 0) ? 1 : 0);
      checkOutput($sformatf("rr%0d_mem_ready", i), mem_ready, (i % 2 == 0) ? 0 : 1);
      stepClock();
      checkOutput($sformatf("rr%0d_regwrite", i), RegWrite, 1);
      checkOutput($sformatf("rr%0d_escreg", i), EscReg, (i % 2 == 0) ? 1 : 2);
      checkOutput($sformatf("rr%0d_writedata", i), WriteData, (i % 2 == 0) ? 8'h11 : 8'h22);
      checkOutput($sformatf("rr%0d_last_grant", i), last_grant, (i % 2 == 0) ? 0 : 1);
    end
    applyStimulus(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00);
    stepClock();
    checkOutput("rr_end_regwrite", RegWrite, 0);

    // Same-address collision: ALU wins first, mem's data lands last.
    pulseReset();
    applyStimulus(1'b1, 3'd5, 8'hAA, 1'b1, 3'd5, 8'hBB);
    #1;
    checkOutput("coll_alu_ready", alu_ready, 1);
    stepClock();
    checkOutput("coll_first_regwrite", RegWrite, 1);
    checkOutput("coll_first_data", WriteData, 8'hAA);
    applyStimulus(1'b0, 3'd0, 8'h00, 1'b1, 3'd5, 8'hBB);
    #1;
    checkOutput("coll_mem_ready", mem_ready, 1);
    stepClock();
    applyStimulus(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00);
    checkOutput("coll_second_regwrite", RegWrite, 1);
    checkOutput("coll_second_escreg", EscReg, 5);
    checkOutput("coll_second_data", WriteData, 8'hBB);
    stepClock();
    checkOutput("coll_final_data", WriteData, 8'hBB);

    // r0 discard: 300 ALU transfers to r0, counter saturates at 255.
    pulseReset();
    applyStimulus(1'b1, 3'd0, 8'h77, 1'b0, 3'd0, 8'h00);
    for (int i = 0; i < 300; i++) begin
      stepClock();
      if (RegWrite !== 1'b0) writePulses++;
      if (i == 0) checkOutput("r0_first_count", drop_count, 1);
    end
    applyStimulus(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00);
    checkOutput("r0_pulses", writePulses[7:0], 0);
    checkOutput("r0_drop_count", drop_count, 8'hFF);
    checkOutput("r0_last_grant", last_grant, 0);
    checkOutput("r0_writedata_hold", WriteData, 0);
    pulseReset();
    checkOutput("r0_count_cleared", drop_count, 0);
    checkOutput("r0_last_grant_reset", last_grant, 1);

    // Asynchronous reset during the cycle of a pending write.
    applyStimulus(1'b0, 3'd0, 8'h00, 1'b1, 3'd6, 8'hC3);
    stepClock();
    checkOutput("arst_pre_regwrite", RegWrite, 1);
    checkOutput("arst_pre_data", WriteData, 8'hC3);
    reset = 1'b1;
    #1;
    checkOutput("arst_regwrite", RegWrite, 0);
    checkOutput("arst_escreg", EscReg, 0);
    checkOutput("arst_mem_ready", mem_ready, 0);
    stepClock();
    applyStimulus(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00);
    reset = 1'b0;
    stepClock();
    checkOutput("arst_post1_regwrite", RegWrite, 0);
    stepClock();
    checkOutput("arst_post2_regwrite", RegWrite, 0);

    // Idle gaps on mem only: one pulse per transfer, none after idle edges.
    for (int i = 0; i < 6; i++) begin
      if (i % 2 == 0) applyStimulus(1'b0, 3'd0, 8'h00, 1'b1, 3'd4, 8'(8'h10 + i));
      else            applyStimulus(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00);
      stepClock();
      checkOutput($sformatf("gap%0d_regwrite", i), RegWrite, (i % 2 == 0) ? 1 : 0);
      checkOutput($sformatf("gap%0d_writedata", i), WriteData, (i % 2 == 0) ? 8'(8'h10 + i) : 8'(8'h10 + i - 1));
      checkOutput($sformatf("gap%0d_escreg", i), EscReg, 4);
    end

    $display("%0d/%0d checks passed", checksPassed, checksTotal);
    $finish;
  end

endmodule
